vectored_int_ctrl: RTL and testbench

- Parametrised successor to the core's two-source interrupt controller.
- Accepts NUM_SRC interrupt sources, each individually maskable and with per-source edge or level mode; source 0 is the non-maskable exception line.
- Selects the highest-priority pending source and presents its vector address to the hazard control unit.
- Tracks nested in-service interrupts on a small priority stack, so a higher-priority source preempts a running handler.

---
 rtl/vectored_int_ctrl_pkg.sv | 16 +
 rtl/int_prio_stack.sv | 49 ++++
 rtl/vectored_int_ctrl.sv | 156 +++++++++++++++
 tb/tb_vectored_int_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vectored_int_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller and the hazard control unit.
package vectored_int_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } int_state_e;

  localparam int unsigned             HAZ_ST_W       = 4;
  localparam logic [HAZ_ST_W-1:0]     HAZ_SAFE_STATE = 4'd0;

  localparam int unsigned             DEF_ADDR_W     = 14;
  localparam logic [DEF_ADDR_W-1:0]   DEF_VEC_BASE   = 14'h0004;
  localparam int unsigned             DEF_VEC_STRIDE = 2;

endpackage

// File: rtl/int_prio_stack.sv
// LIFO of in-service interrupt ids; push together with pop replaces the top entry.
module int_prio_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 3,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [ID_W-1:0]  push_id,
  output logic [ID_W-1:0]  top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign top_idx  = IDX_W'(count_q - CNT_W'(1));
  assign push_idx = IDX_W'(count_q);
  assign top      = empty ? '0 : mem_q[top_idx];
  assign count    = count_q;

  // Pop-then-push in one cycle collapses to overwriting the top slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_pop && push) begin
      mem_q[top_idx] <= push_id;
    end else if (do_pop) begin
      count_q <= count_q - CNT_W'(1);
    end else if (push && !full) begin
      mem_q[push_idx] <= push_id;
      count_q         <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vectored_int_ctrl.sv
// Prioritised, maskable, nestable interrupt controller presenting a vector to the hazard unit.
module vectored_int_ctrl
  import vectored_int_ctrl_pkg::*;
#(
  parameter int unsigned        NUM_SRC    = 8,
  parameter int unsigned        ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]  VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
  parameter int unsigned        VEC_STRIDE = DEF_VEC_STRIDE,
  parameter int unsigned        ST_W       = HAZ_ST_W,
  parameter logic [ST_W-1:0]    SAFE_STATE = ST_W'(HAZ_SAFE_STATE),
  parameter int unsigned        NEST_DEPTH = 4,
  localparam int unsigned       ID_W       = $clog2(NUM_SRC)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic [NUM_SRC-1:0] int_mask,
  input  logic               global_en,
  input  logic [ST_W-1:0]    hazard_unit_state,
  input  logic               int_ack,
  input  logic               int_return,
  output logic               interrupt,
  output logic [ADDR_W-1:0]  int_vec_addr,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service,
  output logic               stack_overflow
);

  localparam int unsigned CNT_W = $clog2(NEST_DEPTH + 1);

  int_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    win_id;
  logic [ADDR_W-1:0]  vec_q, vec_d;
  logic               intr_q;
  logic               ovf_q, ovf_d;
  logic               any_elig;
  logic               take_ack;
  logic               stk_push, stk_pop;
  logic               stk_full, stk_empty;
  logic [ID_W-1:0]    stk_top;
  logic [CNT_W-1:0]   stk_count;

  // Edge sources latch until acked (set beats clear); level sources just follow the line.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_mode[i]) begin
        pending_d[i] = (irq_in[i] & ~irq_prev_q[i]) |
                       (pending_q[i] & ~(take_ack && (id_q == ID_W'(i))));
      end else begin
        pending_d[i] = irq_in[i];
      end
    end
  end

  // Only sources strictly higher in priority than the running handler may preempt it.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending_q[i] &
                    ((i == 0) | (int_mask[i] & global_en)) &
                    (stk_empty | (ID_W'(i) < stk_top));
    end
  end

  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  assign any_elig = |eligible;

  // Request id and vector are captured on entry to REQ and held until acked.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    vec_d    = vec_q;
    ovf_d    = ovf_q;
    take_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          if (stk_full && (win_id != '0)) begin
            ovf_d = 1'b1;
          end else if (hazard_unit_state == SAFE_STATE) begin
            state_d = ST_REQ;
            id_d    = win_id;
            vec_d   = VEC_BASE + ADDR_W'(win_id) * ADDR_W'(VEC_STRIDE);
          end
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          take_ack = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A full-stack ack can only be source 0, which overwrites the top via pop+push.
  assign stk_push = take_ack;
  assign stk_pop  = int_return | (take_ack & stk_full);

  int_prio_stack #(
    .DEPTH (NEST_DEPTH),
    .ID_W  (ID_W)
  ) u_stack (
    .clock   (clock),
    .reset   (reset),
    .push    (stk_push),
    .pop     (stk_pop),
    .push_id (id_q),
    .top     (stk_top),
    .count   (stk_count),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      id_q       <= '0;
      vec_q      <= '0;
      intr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      id_q       <= id_d;
      vec_q      <= vec_d;
      intr_q     <= (state_d == ST_REQ);
      ovf_q      <= ovf_d;
    end
  end

  assign interrupt      = intr_q;
  assign int_id         = id_q;
  assign int_vec_addr   = vec_q;
  assign pending        = pending_q;
  assign stack_overflow = ovf_q;
  assign in_service     = (stk_count != '0);

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Directed plus randomized bench for vectored_int_ctrl against a queue-based reference model.
module tb_vectored_int_ctrl;

  localparam int NS     = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 14;
  localparam int BASE   = 4;
  localparam int STRIDE = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [NS-1:0] irq_in;
  logic [NS-1:0] edge_mode;
  logic [NS-1:0] int_mask;
  logic          global_en;
  logic [3:0]    hazard_unit_state;
  logic          int_ack;
  logic          int_return;
  logic          interrupt;
  logic [13:0]   int_vec_addr;
  logic [2:0]    int_id;
  logic [NS-1:0] pending;
  logic          in_service;
  logic          stack_overflow;

  vectored_int_ctrl #(.NEST_DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .irq_in            (irq_in),
    .edge_mode         (edge_mode),
    .int_mask          (int_mask),
    .global_en         (global_en),
    .hazard_unit_state (hazard_unit_state),
    .int_ack           (int_ack),
    .int_return        (int_return),
    .interrupt         (interrupt),
    .int_vec_addr      (int_vec_addr),
    .int_id            (int_id),
    .pending           (pending),
    .in_service        (in_service),
    .stack_overflow    (stack_overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_prev [NS];
  bit m_pend [NS];
  int m_stack [$];
  bit m_req;
  int m_id;
  int m_vec;
  bit m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NS; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One clock of the behavioural model, evaluated from the inputs present at the edge.
  task automatic model_clock();
    int  win;
    bit  full_before;
    bit  take;
    int  top;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        m_prev[i] = 0;
        m_pend[i] = 0;
      end
      m_stack.delete();
      m_req = 0; m_id = 0; m_vec = 0; m_ovf = 0;
      return;
    end
    full_before = (m_stack.size() == DEPTH);
    top = (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : NS;
    win = -1;
    for (int i = 0; i < NS; i++) begin
      if (win < 0 && m_pend[i] && (i == 0 || (int_mask[i] && global_en)) && i < top)
        win = i;
    end
    take = m_req && int_ack;
    for (int i = 0; i < NS; i++) begin
      if (edge_mode[i])
        m_pend[i] = (irq_in[i] && !m_prev[i]) || (m_pend[i] && !(take && m_id == i));
      else
        m_pend[i] = irq_in[i];
      m_prev[i] = irq_in[i];
    end
    if (int_return && m_stack.size() > 0) void'(m_stack.pop_back());
    if (take) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(m_id);
      else m_stack[m_stack.size()-1] = m_id;
    end
    if (m_req) begin
      if (int_ack) m_req = 0;
    end else if (win >= 0) begin
      if (full_before && win != 0) m_ovf = 1;
      else if (hazard_unit_state == 4'd0) begin
        m_req = 1;
        m_id  = win;
        m_vec = (BASE + win * STRIDE) % (1 << ADDR_W);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_clock();
    #1;
    check_eq("interrupt",      32'(interrupt),      32'(m_req));
    check_eq("int_id",         32'(int_id),         32'(m_id));
    check_eq("int_vec_addr",   32'(int_vec_addr),   32'(m_vec));
    check_eq("pending",        32'(pending),        m_pend_vec());
    check_eq("in_service",     32'(in_service),     32'(m_stack.size() != 0));
    check_eq("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
  endtask

  task automatic pulse(input logic [NS-1:0] bits);
    irq_in = bits;
    step();
    irq_in = '0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  task automatic do_ret();
    int_return = 1'b1;
    step();
    int_return = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (!interrupt && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_req_seen"}, 32'(interrupt), 32'd1);
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; edge_mode = '1; int_mask = '1; global_en = 1'b1;
    hazard_unit_state = 4'd0; int_ack = 1'b0; int_return = 1'b0;
    step(); step();
    check_eq("rst_interrupt", 32'(interrupt), 32'd0);
    check_eq("rst_vec", 32'(int_vec_addr), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    reset = 1'b0;
    step();

    // 1: single edge source
    pulse(8'h08);
    wait_req("t1", 1);
    check_eq("t1_id", 32'(int_id), 32'd3);
    check_eq("t1_vec", 32'(int_vec_addr), 32'h000A);
    do_ack();
    check_eq("t1_pend3", 32'(pending[3]), 32'd0);
    check_eq("t1_insvc", 32'(in_service), 32'd1);
    do_ret();

    // 2: simultaneous sources, lower index first, second blocked until return
    pulse(8'h24);
    wait_req("t2a", 3);
    check_eq("t2_first_id", 32'(int_id), 32'd2);
    do_ack();
    idle_steps(3);
    check_eq("t2_blocked", 32'(interrupt), 32'd0);
    do_ret();
    wait_req("t2b", 3);
    check_eq("t2_second_id", 32'(int_id), 32'd5);
    check_eq("t2_second_vec", 32'(int_vec_addr), 32'h000E);
    do_ack();
    do_ret();

    // 3: nesting
    pulse(8'h10);
    wait_req("t3a", 3);
    do_ack();
    pulse(8'h02);
    wait_req("t3b", 3);
    check_eq("t3_preempt_id", 32'(int_id), 32'd1);
    do_ack();
    do_ret();
    check_eq("t3_insvc_one", 32'(in_service), 32'd1);
    do_ret();
    check_eq("t3_insvc_zero", 32'(in_service), 32'd0);

    // 4: masking and non-maskable source 0
    int_mask = 8'hBF;
    pulse(8'h40);
    idle_steps(3);
    check_eq("t4_pend6", 32'(pending[6]), 32'd1);
    check_eq("t4_masked", 32'(interrupt), 32'd0);
    int_mask = 8'hFF;
    wait_req("t4a", 3);
    check_eq("t4_id6", 32'(int_id), 32'd6);
    do_ack();
    do_ret();
    global_en = 1'b0;
    pulse(8'h01);
    wait_req("t4b", 3);
    check_eq("t4_nmi_vec", 32'(int_vec_addr), 32'h0004);
    do_ack();
    do_ret();
    global_en = 1'b1;

    // 5: hazard state gating
    hazard_unit_state = 4'd3;
    pulse(8'h02);
    idle_steps(3);
    check_eq("t5_gated", 32'(interrupt), 32'd0);
    hazard_unit_state = 4'd0;
    step();
    check_eq("t5_released", 32'(interrupt), 32'd1);
    do_ack();
    do_ret();

    // 6: fill the stack, overflow, source 0 overwrite, reset mid-request
    for (int s = 7; s >= 4; s--) begin
      pulse(NS'(1) << s);
      wait_req("t6_fill", 3);
      do_ack();
    end
    pulse(8'h04);
    idle_steps(3);
    check_eq("t6_ovf", 32'(stack_overflow), 32'd1);
    check_eq("t6_no_req", 32'(interrupt), 32'd0);
    pulse(8'h01);
    wait_req("t6_nmi", 3);
    check_eq("t6_nmi_id", 32'(int_id), 32'd0);
    do_ack();
    do_ret();
    wait_req("t6_after_pop", 3);
    check_eq("t6_id2", 32'(int_id), 32'd2);
    reset = 1'b1;
    irq_in = 8'h08;
    step();
    check_eq("t6_rst_intr", 32'(interrupt), 32'd0);
    check_eq("t6_rst_pend", 32'(pending), 32'd0);
    check_eq("t6_rst_ovf", 32'(stack_overflow), 32'd0);
    reset = 1'b0;
    step();
    check_eq("t6_edge_at_release", 32'(pending[3]), 32'd1);
    irq_in = '0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) edge_mode = NS'($urandom);
      if ($urandom_range(0, 19) == 0) int_mask = NS'($urandom);
      global_en = ($urandom_range(0, 9) != 0);
      hazard_unit_state = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      irq_in = NS'($urandom) & NS'($urandom) & NS'($urandom);
      int_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      int_return = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 599) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
